spi_flash_emu: RTL and testbench

Synthesizable, parametrised SPI NOR-flash slave emulator for SoC boot-path bring-up on FPGA and in simulation. It replaces hand-written SPI flash stimulus with a clocked model that serves the program image to the on-chip bootloader. The model decodes READ, FAST_READ and JEDEC-ID commands, supports all four SPI modes, streams bytes from a word-organised image memory, and is loaded through a side write port.

---
 rtl/spi_flash_emu.sv | 177 +++++++++++++++++
 tb/tb_spi_flash_emu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_emu.sv
`timescale 1ns/1ps
// SPI NOR-flash slave emulator serving READ / FAST_READ / JEDEC-ID from a side-loaded word image in any SPI mode.
// Pin edges act 3 clocks after arrival and spi_miso moves within 4; no backpressure, the SPI master paces everything.
module spi_flash_emu #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 512,
  parameter int          ADDR_BYTES = 3,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          WORD_LE    = 1'b1,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spi_cs,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     active
);

  localparam int BPW    = DATA_W / 8;
  localparam int NBYTES = DEPTH * BPW;
  localparam int AW     = $clog2(NBYTES);
  localparam int WAW    = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE} state_t;

  state_t state, nxt;

  logic [1:0]        cs_s, mosi_s;
  logic [2:0]        clk_s;
  logic              cs_sync, mosi_b, lead, trail, sample, shift;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt, id_cnt;
  logic [6:0]        in_sr;
  logic [7:0]        in_byte, out_sr, out_byte, mem_byte;
  logic              fast, miso_q;
  logic [AW-1:0]     addr, lane, lane_sel;
  logic [WAW-1:0]    word_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  // CS resets to "deselected" so active/oe drop the instant reset asserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      clk_s  <= {3{CPOL}};
    end else begin
      cs_s   <= {cs_s[0], spi_cs};
      mosi_s <= {mosi_s[0], spi_mosi};
      clk_s  <= {clk_s[1:0], spi_clk};
    end
  end

  assign cs_sync     = cs_s[1];
  assign mosi_b      = mosi_s[1];
  assign lead        = (clk_s[2] == CPOL) && (clk_s[1] != CPOL);
  assign trail       = (clk_s[2] != CPOL) && (clk_s[1] == CPOL);
  assign sample      = CPHA ? trail : lead;
  assign shift       = CPHA ? lead : trail;
  assign in_byte     = {in_sr, mosi_b};
  assign active      = ~cs_sync;
  assign spi_miso_oe = ~cs_sync;
  assign spi_miso    = miso_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cs_sync) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: nxt = CMD;
        CMD: begin
          if (sample && bit_cnt == 3'd7) begin
            case (in_byte)
              8'h03, 8'h0B: nxt = ADDR;
              8'h9F:        nxt = ID;
              default:      nxt = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sample && bit_cnt == 3'd7 && byte_cnt == 2'(ADDR_BYTES - 1))
            nxt = fast ? DUMMY : DATA;
        end
        DUMMY: begin
          if (sample && bit_cnt == 3'd7) nxt = DATA;
        end
        default: nxt = state;
      endcase
    end
  end

  // Read-before-write: a load hitting the word being fetched returns the old word.
  always_ff @(posedge clock) begin
    if (load_we) mem[load_addr] <= load_data;
    mem_q <= mem[word_idx];
  end

  assign word_idx = WAW'(addr / AW'(BPW));
  assign lane     = addr % AW'(BPW);
  assign lane_sel = WORD_LE ? lane : AW'(BPW - 1) - lane;
  assign mem_byte = 8'(mem_q >> {lane_sel, 3'b000});

  always_comb begin
    out_byte = 8'h00;
    if (state == DATA) begin
      out_byte = mem_byte;
    end else if (state == ID) begin
      case (id_cnt)
        2'd0:    out_byte = JEDEC_ID[23:16];
        2'd1:    out_byte = JEDEC_ID[15:8];
        2'd2:    out_byte = JEDEC_ID[7:0];
        default: out_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      id_cnt   <= '0;
      in_sr    <= '0;
      out_sr   <= '0;
      fast     <= 1'b0;
      addr     <= '0;
      miso_q   <= 1'b0;
    end else if (cs_sync) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      id_cnt   <= '0;
      in_sr    <= '0;
      out_sr   <= '0;
      fast     <= 1'b0;
      addr     <= '0;
      miso_q   <= 1'b0;
    end else begin
      if (sample && (state == CMD || state == ADDR || state == DUMMY)) begin
        bit_cnt <= bit_cnt + 3'd1;
        in_sr   <= in_byte[6:0];
        if (state == CMD && bit_cnt == 3'd7) fast <= (in_byte == 8'h0B);
        if (state == ADDR) begin
          addr <= {addr[AW-2:0], mosi_b};
          if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
        end
      end
      // The first shift edge of every output byte loads the freshly fetched byte.
      if (shift && (state == DATA || state == ID)) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) begin
          miso_q <= out_byte[7];
          out_sr <= {out_byte[6:0], 1'b0};
        end else begin
          miso_q <= out_sr[7];
          out_sr <= {out_sr[6:0], 1'b0};
        end
        if (bit_cnt == 3'd7) begin
          if (state == DATA) addr <= (addr == AW'(NBYTES - 1)) ? '0 : addr + AW'(1);
          else if (id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_emu.sv
`timescale 1ns/1ps
// Bench: five emulator instances (modes 0..3 little-endian, plus mode 0 big-endian) driven by a bit-banged SPI master;
// a passive monitor deserialises miso on each instance's sample edge and scores bytes against an expectation queue.
module tb_spi_flash_emu;

  localparam int N = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] cs    = '1;
  logic [N-1:0] sclk  = 5'b01100;
  logic         mosi  = 1'b0;
  logic [N-1:0] miso, oe, act;
  logic         load_we   = 1'b0;
  logic [8:0]   load_addr = '0;
  logic [31:0]  load_data = '0;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         sel      = 0;
  int         hdr      = 0;
  string      cur_name = "";
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  always #5 clock = ~clock;

  for (genvar i = 0; i < N; i++) begin : g_dut
    spi_flash_emu #(
      .DATA_W(32), .DEPTH(512), .ADDR_BYTES(3),
      .CPOL((i == 2) || (i == 3)), .CPHA((i == 1) || (i == 3)),
      .WORD_LE(i != 4), .JEDEC_ID(24'hEF4018)
    ) u_dut (
      .clock(clock), .reset(reset), .spi_cs(cs[i]), .spi_clk(sclk[i]), .spi_mosi(mosi),
      .spi_miso(miso[i]), .spi_miso_oe(oe[i]), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .active(act[i])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  task automatic half();
    repeat (8) @(negedge clock);
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    @(negedge clock);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_we = 1'b0;
  endtask

  task automatic send(input logic [63:0] v, input int n);
    tx_q.delete();
    for (int k = 0; k < n; k++) tx_q.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic expect_bytes(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic spi_run(input int d, input int nbits, input bit keep_cs);
    logic       cpol, cpha, bv;
    logic [7:0] b;
    cpol = (d == 2) || (d == 3);
    cpha = (d == 1) || (d == 3);
    sel   = d;
    cs[d] = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      b  = (i / 8 < tx_q.size()) ? tx_q[i/8] : 8'h00;
      bv = b[7 - i % 8];
      if (!cpha) begin
        mosi = bv; half(); sclk[d] = ~cpol; half(); sclk[d] = cpol;
      end else begin
        sclk[d] = ~cpol; mosi = bv; half(); sclk[d] = cpol; half();
      end
    end
    half();
    if (!keep_cs) begin
      cs[d] = 1'b1; mosi = 1'b0; half();
    end
  endtask

  task automatic txn(input string name, input int d, input logic [63:0] cmd, input int ncmd, input int h,
                     input logic [63:0] exp, input int nexp, input int nbits);
    cur_name = name;
    hdr      = h;
    send(cmd, ncmd);
    expect_bytes(exp, nexp);
    spi_run(d, nbits, 1'b0);
    check({name, " drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: samples miso on the selected instance's sample edge, past its header bytes.
  initial begin
    logic       prev, cur, cp, ch;
    logic [7:0] rx;
    int         nb;
    prev = 1'b0; rx = 8'h00; nb = 0;
    forever begin
      @(posedge clock); #2;
      cp  = (sel == 2) || (sel == 3);
      ch  = (sel == 1) || (sel == 3);
      cur = sclk[sel];
      if (cs[sel] || !reset) begin
        nb   = 0;
        prev = cur;
      end else if (cur != prev) begin
        if ((prev == cp) != ch) begin
          rx = {rx[6:0], miso[sel]};
          nb++;
          if (nb % 8 == 0 && nb / 8 > hdr) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL %s extra byte: got %0h, want none", cur_name, rx);
            end else begin
              check($sformatf("%s byte %0d", cur_name, nb / 8 - hdr - 1), 32'(rx), 32'(exp_q.pop_front()));
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset miso %0d", d), 32'(miso[d]), 32'd0);
      check($sformatf("reset oe %0d", d), 32'(oe[d]), 32'd0);
      check($sformatf("reset active %0d", d), 32'(act[d]), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    load(9'd0, 32'h0000_0093);
    load(9'd1, 32'h1234_5678);
    load(9'd2, 32'hCAFE_F00D);
    load(9'd511, 32'h1122_3344);

    txn("m0 read0", 0, 64'h03_00_00_00, 4, 4, 64'h93_00_00_00_78_56_34_12, 8, 96);
    txn("m0 wrap", 0, 64'h03_00_07_FF, 4, 4, 64'h11_93, 2, 48);
    txn("m0 jedec", 0, 64'h9F, 1, 1, 64'hEF_40_18_00, 4, 40);
    txn("m0 unknown", 0, 64'hAB, 1, 1, 64'h00_00_00_00, 4, 40);
    txn("m0 after unknown", 0, 64'h03_00_00_04, 4, 4, 64'h78_56_34_12, 4, 64);
    txn("m0 abort", 0, 64'h03_0F_FF, 3, 99, 64'h0, 0, 20);
    txn("m0 after abort", 0, 64'h03_00_00_04, 4, 4, 64'h78_56_34_12, 4, 64);
    txn("m1 read0", 1, 64'h03_00_00_00, 4, 4, 64'h93_00_00_00_78_56_34_12, 8, 96);
    txn("m2 read0", 2, 64'h03_00_00_00, 4, 4, 64'h93_00_00_00_78_56_34_12, 8, 96);
    txn("m3 read0", 3, 64'h03_00_00_00, 4, 4, 64'h93_00_00_00_78_56_34_12, 8, 96);

    load(9'd1, 32'hAABB_CCDD);
    txn("be fast", 4, 64'h0B_00_00_05_00, 5, 5, 64'hBB_CC_DD_CA, 4, 72);

    // Two bits into byte 0xDD: miso carries bit 6 (=1) when reset hits.
    cur_name = "reset mid";
    hdr      = 99;
    send(64'h03_00_00_04, 4);
    spi_run(0, 33, 1'b1);
    check("pre-reset miso", 32'(miso[0]), 32'd1);
    check("pre-reset oe", 32'(oe[0]), 32'd1);
    check("pre-reset active", 32'(act[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("mid reset miso", 32'(miso[0]), 32'd0);
    check("mid reset oe", 32'(oe[0]), 32'd0);
    check("mid reset active", 32'(act[0]), 32'd0);
    cs[0] = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    txn("m0 after reset", 0, 64'h03_00_00_00, 4, 4, 64'h93_00_00_00, 4, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
